mnist_frame_ctrl: RTL and testbench

MNIST_FRAME_CTRL -- requirements
Module: mnist_frame_ctrl

---
 rtl/mnist_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_mnist_frame_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mnist_frame_ctrl.sv
// mnist_frame_ctrl: turns a UART byte stream into framed pixel strobes for the
// digit-recognition core. A sync byte opens a frame of PIXELS pixels. The block
// then waits for the core's result. Receive and result timeouts abort the
// frame, flush the core and report an error code.
module mnist_frame_ctrl #(
  parameter int          PIXELS      = 784,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int          RX_TIMEOUT  = 5_000_000,
  parameter int          RES_TIMEOUT = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       core_result_valid,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  output logic       core_flush,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int PC_W    = $clog2(PIXELS + 1);
  localparam int TMO_MAX = (RX_TIMEOUT > RES_TIMEOUT) ? RX_TIMEOUT : RES_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);

  localparam logic [PC_W-1:0]  LAST_PIX = PC_W'(PIXELS - 1);
  localparam logic [PC_W-1:0]  FULL_PIX = PC_W'(PIXELS);
  localparam logic [TMO_W-1:0] RX_LIM   = TMO_W'(RX_TIMEOUT);
  localparam logic [TMO_W-1:0] RES_LIM  = TMO_W'(RES_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    pix_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W-1:0]   tmo_inc;

  // The counter leaves its state before it can pass the larger limit, so this
  // sum never wraps.
  assign tmo_inc = tmo_cnt + TMO_W'(1);

  // Dropped-byte counter sticks at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      tmo_cnt    <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= 8'd0;
      core_flush <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      busy       <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      pix_valid  <= 1'b0;
      core_flush <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state    <= RECV;
            busy     <= 1'b1;
            pix_cnt  <= '0;
            tmo_cnt  <= '0;
            drop_cnt <= 8'd0;
          end
        end
        RECV: begin
          // An arriving byte always beats a timeout firing in the same cycle;
          // sync bytes are ordinary pixels here.
          if (rx_valid) begin
            pix_valid <= 1'b1;
            pix_data  <= rx_byte;
            tmo_cnt   <= '0;
            if (pix_cnt == LAST_PIX) begin
              pix_cnt <= FULL_PIX;
              state   <= WAIT_RES;
            end else begin
              pix_cnt <= pix_cnt + PC_W'(1);
            end
          end else if (tmo_inc >= RX_LIM) begin
            frame_err  <= 1'b1;
            core_flush <= 1'b1;
            err_code   <= 2'd1;
            busy       <= 1'b0;
            tmo_cnt    <= '0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        WAIT_RES: begin
          // Bytes here are counted and discarded, even one coinciding with
          // the result strobe.
          if (rx_valid) begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
          if (core_result_valid) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            tmo_cnt    <= '0;
            state      <= IDLE;
          end else if (tmo_inc >= RES_LIM) begin
            frame_err  <= 1'b1;
            core_flush <= 1'b1;
            err_code   <= 2'd2;
            busy       <= 1'b0;
            tmo_cnt    <= '0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// tb_mnist_frame_ctrl: directed frame scenarios followed by randomized byte and
// result traffic, each cycle compared against a behavioural frame model.
module tb_mnist_frame_ctrl;

  localparam int         PIXELS      = 4;
  localparam logic [7:0] SYNC        = 8'hAA;
  localparam int         RX_TIMEOUT  = 20;
  localparam int         RES_TIMEOUT = 50;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       core_result_valid;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       core_flush;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [7:0] drop_cnt;

  mnist_frame_ctrl #(
    .PIXELS      (PIXELS),
    .SYNC_BYTE   (SYNC),
    .RX_TIMEOUT  (RX_TIMEOUT),
    .RES_TIMEOUT (RES_TIMEOUT)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .rx_byte           (rx_byte),
    .rx_valid          (rx_valid),
    .core_result_valid (core_result_valid),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .core_flush        (core_flush),
    .frame_done        (frame_done),
    .frame_err         (frame_err),
    .err_code          (err_code),
    .busy              (busy),
    .drop_cnt          (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural model: "what a frame receiver should have shown after this cycle".
  // Phase 0 = hunting for sync, 1 = collecting pixels, 2 = awaiting result.
  int         m_phase;
  int         m_got;      // pixels collected in the current frame
  int         m_quiet;    // cycles since the last progress event in this phase
  int         m_drops;
  int         m_code;
  bit         e_pix, e_flush, e_done, e_err, e_busy;
  logic [7:0] e_data;

  task automatic model_reset();
    m_phase = 0; m_got = 0; m_quiet = 0; m_drops = 0; m_code = 0;
    e_pix = 0; e_flush = 0; e_done = 0; e_err = 0; e_busy = 0; e_data = 8'd0;
  endtask

  task automatic model_abort(input int code);
    e_err = 1; e_flush = 1; m_code = code; m_phase = 0; e_busy = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit r);
    e_pix = 0; e_flush = 0; e_done = 0; e_err = 0;
    if (m_phase == 0) begin
      if (v && b == SYNC) begin
        m_phase = 1; m_got = 0; m_quiet = 0; m_drops = 0; e_busy = 1;
      end
    end else if (m_phase == 1) begin
      if (v) begin
        e_pix = 1; e_data = b; m_got++; m_quiet = 0;
        if (m_got == PIXELS) m_phase = 2;
      end else begin
        m_quiet++;
        if (m_quiet >= RX_TIMEOUT) model_abort(1);
      end
    end else begin
      if (v && m_drops < 255) m_drops++;
      if (r) begin
        e_done = 1; m_phase = 0; e_busy = 0;
      end else begin
        m_quiet++;
        if (m_quiet >= RES_TIMEOUT) model_abort(2);
      end
    end
  endtask

  task automatic compare_all();
    chk("pix_valid", 32'(pix_valid), 32'(e_pix));
    if (e_pix) chk("pix_data", 32'(pix_data), 32'(e_data));
    chk("core_flush", 32'(core_flush), 32'(e_flush));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // One clock: check what the last edge produced, then present new inputs.
  task automatic cyc(input bit v, input logic [7:0] b, input bit r);
    @(negedge sys_clk);
    compare_all();
    rx_valid = v; rx_byte = b; core_result_valid = r;
    model_step(v, b, r);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic result();
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  int rate;

  initial begin
    sys_rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; core_result_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    compare_all();
    sys_rst_n = 1'b1;

    // Clean frame with a result
    send(SYNC); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(3); result(); idle(3);

    // Junk before sync; a second sync byte is a pixel
    send(8'h55); send(SYNC); send(SYNC); send(8'h10); send(8'h11); send(8'h12);
    idle(2); send(8'h13); result(); idle(2);

    // Receive timeout, then a stray byte is ignored
    send(SYNC); send(8'h01); send(8'h02); idle(RX_TIMEOUT); idle(2);
    send(8'h03); idle(3);

    // Byte landing exactly on the timeout cycle wins
    send(SYNC); idle(RX_TIMEOUT - 1); send(8'h21);
    idle(RX_TIMEOUT - 1); send(8'h22); send(8'h23); send(8'h24);
    result(); idle(2);

    // Result timeout with dropped bytes
    send(SYNC); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h31); send(SYNC); send(8'h33); idle(RES_TIMEOUT); idle(3);

    // Byte coinciding with the result is dropped, not a sync
    send(SYNC); send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    cyc(1'b1, SYNC, 1'b1); idle(3);

    // Asynchronous reset mid-frame
    send(SYNC); send(8'h01); send(8'h02);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_pix_data", 32'(pix_data), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    rx_valid = 1'b0; core_result_valid = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    send(SYNC); send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    idle(2); result(); idle(3);

    // Randomized traffic with varying byte rates
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(2))
        0: rate = 2;
        1: rate = 30;
        default: rate = 85;
      endcase
      for (int i = 0; i < 100; i++) begin
        cyc($urandom_range(99) < rate,
            ($urandom_range(1) == 1) ? SYNC : 8'($urandom_range(255)),
            $urandom_range(99) < 3);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
